// File: rtl/clk_monitor_supervisor.sv
// Supervises the clock-frequency detector: resynchronises its flag/count results, samples them once per window,
// qualifies them over several windows and reports lock/fault state, alarm pulses and min/max/fault statistics.
module clk_monitor_supervisor #(
    parameter int CLK_NUM      = 156,
    parameter int TOL          = 5,
    parameter int WIN_CYC      = 51,
    parameter int SAMPLE_PHASE = 40,
    parameter int GOOD_WIN     = 16,
    parameter int BAD_WIN      = 3
) (
    input  logic        clk_25M_dect,
    input  logic        rst,
    input  logic        enable,
    input  logic        clk_flag_in,
    input  logic [9:0]  clk_cnt_in,
    input  logic        clr_stat,
    output logic [1:0]  state,
    output logic        locked,
    output logic        fault,
    output logic        alarm_pulse,
    output logic        sample_valid,
    output logic [9:0]  cnt_last,
    output logic [9:0]  cnt_min,
    output logic [9:0]  cnt_max,
    output logic [15:0] fault_cnt
);

    localparam int TW = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam int GW = $clog2(GOOD_WIN + 1);
    localparam int BW = $clog2(BAD_WIN + 1);

    localparam logic [9:0]    CNT_LO   = 10'(CLK_NUM - TOL);
    localparam logic [9:0]    CNT_HI   = 10'(CLK_NUM + TOL);
    localparam logic [TW-1:0] T_LAST   = TW'(WIN_CYC - 1);
    localparam logic [TW-1:0] T_SAMPLE = TW'(SAMPLE_PHASE);
    localparam logic [GW-1:0] GOOD_TOP = GW'(GOOD_WIN - 1);
    localparam logic [BW-1:0] BAD_TOP  = BW'(BAD_WIN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    state_t          state_q, state_nx;
    logic            flag_meta, flag_s;
    logic [9:0]      c1, c2;
    logic [TW-1:0]   timer;
    logic [GW-1:0]   good_run, good_nx;
    logic [BW-1:0]   bad_run, bad_nx;
    logic            eval, sample_good, fault_evt;

    // Flag gets a plain 2-FF synchroniser; the count bus is only trusted when two consecutive captures agree.
    always_ff @(posedge clk_25M_dect) begin
        if (rst) begin
            flag_meta <= 1'b0;
            flag_s    <= 1'b0;
            c1        <= '0;
            c2        <= '0;
        end else begin
            flag_meta <= clk_flag_in;
            flag_s    <= flag_meta;
            c1        <= clk_cnt_in;
            c2        <= c1;
        end
    end

    always_ff @(posedge clk_25M_dect) begin
        if (rst || !enable || state_q == IDLE) begin
            timer <= '0;
        end else if (timer == T_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign eval        = enable && (state_q != IDLE) && (timer == T_SAMPLE) && (c1 == c2);
    assign sample_good = flag_s && (c2 >= CNT_LO) && (c2 <= CNT_HI);

    always_ff @(posedge clk_25M_dect) begin
        if (rst) begin
            state_q  <= IDLE;
            good_run <= '0;
            bad_run  <= '0;
        end else begin
            state_q  <= state_nx;
            good_run <= good_nx;
            bad_run  <= bad_nx;
        end
    end

    always_comb begin
        state_nx  = state_q;
        good_nx   = good_run;
        bad_nx    = bad_run;
        fault_evt = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
            good_nx  = '0;
            bad_nx   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_nx = ACQUIRE;
                    good_nx  = '0;
                    bad_nx   = '0;
                end
                ACQUIRE: begin
                    if (eval) begin
                        if (!sample_good) begin
                            good_nx = '0;
                        end else if (good_run == GOOD_TOP) begin
                            state_nx = LOCKED;
                            good_nx  = '0;
                            bad_nx   = '0;
                        end else begin
                            good_nx = good_run + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (eval) begin
                        if (sample_good) begin
                            bad_nx = '0;
                        end else if (bad_run == BAD_TOP) begin
                            state_nx  = FAULT;
                            bad_nx    = '0;
                            fault_evt = 1'b1;
                        end else begin
                            bad_nx = bad_run + 1'b1;
                        end
                    end
                end
                FAULT: begin
                    // The recovering sample already counts toward the next lock.
                    if (eval && sample_good) begin
                        state_nx = ACQUIRE;
                        good_nx  = GW'(1);
                        bad_nx   = '0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        state  = state_q;
        locked = (state_q == LOCKED);
    end

    // An evaluation outranks a coinciding clr_stat, so min/max are re-seeded from that very sample.
    always_ff @(posedge clk_25M_dect) begin
        if (rst) begin
            sample_valid <= 1'b0;
            alarm_pulse  <= 1'b0;
            fault        <= 1'b0;
            fault_cnt    <= '0;
            cnt_last     <= '0;
            cnt_min      <= 10'h3FF;
            cnt_max      <= '0;
        end else begin
            sample_valid <= eval;
            alarm_pulse  <= fault_evt;

            if (eval) begin
                cnt_last <= c2;
                cnt_min  <= (clr_stat || c2 < cnt_min) ? c2 : cnt_min;
                cnt_max  <= (clr_stat || c2 > cnt_max) ? c2 : cnt_max;
            end else if (clr_stat) begin
                cnt_last <= '0;
                cnt_min  <= 10'h3FF;
                cnt_max  <= '0;
            end

            if (fault_evt) begin
                fault <= 1'b1;
                if (clr_stat) begin
                    fault_cnt <= 16'd1;
                end else if (fault_cnt != 16'hFFFF) begin
                    fault_cnt <= fault_cnt + 16'd1;
                end
            end else if (clr_stat) begin
                fault     <= 1'b0;
                fault_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_clk_monitor_supervisor.sv
// Directed bench for clk_monitor_supervisor: lock, tolerance edges, fault/recovery, statistics clear,
// unstable bus, enable drop and mid-run reset, each with hand-derived expectations.
module tb_clk_monitor_supervisor;

    logic        clk_25M_dect = 1'b0;
    logic        rst;
    logic        enable;
    logic        clk_flag_in;
    logic [9:0]  clk_cnt_in;
    logic        clr_stat;
    logic [1:0]  state;
    logic        locked;
    logic        fault;
    logic        alarm_pulse;
    logic        sample_valid;
    logic [9:0]  cnt_last;
    logic [9:0]  cnt_min;
    logic [9:0]  cnt_max;
    logic [15:0] fault_cnt;

    int assertions = 0;
    int failures   = 0;

    clk_monitor_supervisor dut (
        .clk_25M_dect (clk_25M_dect),
        .rst          (rst),
        .enable       (enable),
        .clk_flag_in  (clk_flag_in),
        .clk_cnt_in   (clk_cnt_in),
        .clr_stat     (clr_stat),
        .state        (state),
        .locked       (locked),
        .fault        (fault),
        .alarm_pulse  (alarm_pulse),
        .sample_valid (sample_valid),
        .cnt_last     (cnt_last),
        .cnt_min      (cnt_min),
        .cnt_max      (cnt_max),
        .fault_cnt    (fault_cnt)
    );

    always #20 clk_25M_dect = ~clk_25M_dect;

    // Drives one detector result and waits (bounded) for the evaluation pulse it should produce.
    task automatic wait_sample(input logic [9:0] cnt, input logic flag);
        bit seen = 1'b0;
        clk_cnt_in  = cnt;
        clk_flag_in = flag;
        for (int i = 0; i < 150 && !seen; i++) begin
            @(negedge clk_25M_dect);
            if (sample_valid === 1'b1) seen = 1'b1;
        end
        assertions++;
        if (!seen) begin
            failures++;
            $display("[TB] FAIL sample_timeout: sample_valid never seen within 150 cycles, cnt=%0d flag=%0b", cnt, flag);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; clr_stat = 1'b0; clk_cnt_in = 10'd156; clk_flag_in = 1'b1;
        repeat (3) @(negedge clk_25M_dect);
        assertions++;
        if ({state, locked, fault, alarm_pulse, sample_valid} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got st=%0d lk=%0b f=%0b al=%0b sv=%0b, want all 0",
                     state, locked, fault, alarm_pulse, sample_valid);
        end
        assertions++;
        if ({cnt_last, cnt_min, cnt_max, fault_cnt} !== {10'd0, 10'h3FF, 10'd0, 16'd0}) begin
            failures++;
            $display("[TB] FAIL reset_stats: got last=%0d min=%h max=%0d fc=%0d, want 0/3ff/0/0",
                     cnt_last, cnt_min, cnt_max, fault_cnt);
        end
        rst = 1'b0;
        @(negedge clk_25M_dect);
        assertions++;
        if (state !== 2'd0) begin
            failures++;
            $display("[TB] FAIL idle_hold: state=%0d want 0", state);
        end
    endtask

    task automatic test_lock();
        enable = 1'b1;
        @(negedge clk_25M_dect);
        assertions++;
        if (state !== 2'd1) begin
            failures++;
            $display("[TB] FAIL idle_to_acquire: state=%0d want 1", state);
        end
        for (int i = 1; i <= 16; i++) begin
            wait_sample(10'd156, 1'b1);
            assertions++;
            if (state !== ((i == 16) ? 2'd2 : 2'd1) || locked !== (i == 16)) begin
                failures++;
                $display("[TB] FAIL lock_step%0d: state=%0d locked=%0b, want %0d/%0b",
                         i, state, locked, (i == 16) ? 2 : 1, (i == 16));
            end
            if (i == 1) begin
                @(negedge clk_25M_dect);
                assertions++;
                if (sample_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL sv_width: sample_valid=%0b one cycle later, want 0", sample_valid);
                end
            end
        end
        assertions++;
        if ({cnt_last, cnt_min, cnt_max} !== {10'd156, 10'd156, 10'd156}) begin
            failures++;
            $display("[TB] FAIL lock_stats: last=%0d min=%0d max=%0d, want 156/156/156", cnt_last, cnt_min, cnt_max);
        end
    endtask

    logic [9:0] tol_cnt  [8] = '{10'd151, 10'd161, 10'd150, 10'd162, 10'd156, 10'd150, 10'd162, 10'd156};
    logic       tol_flag [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [9:0] tol_min  [8] = '{10'd151, 10'd151, 10'd150, 10'd150, 10'd150, 10'd150, 10'd150, 10'd150};
    logic [9:0] tol_max  [8] = '{10'd156, 10'd161, 10'd161, 10'd162, 10'd162, 10'd162, 10'd162, 10'd162};

    task automatic test_tolerance();
        for (int k = 0; k < 8; k++) begin
            wait_sample(tol_cnt[k], tol_flag[k]);
            assertions++;
            if (state !== ((k == 7) ? 2'd3 : 2'd2) || alarm_pulse !== (k == 7) || cnt_last !== tol_cnt[k]) begin
                failures++;
                $display("[TB] FAIL tol_step%0d: state=%0d alarm=%0b last=%0d, want %0d/%0b/%0d",
                         k, state, alarm_pulse, cnt_last, (k == 7) ? 3 : 2, (k == 7), tol_cnt[k]);
            end
            assertions++;
            if (cnt_min !== tol_min[k] || cnt_max !== tol_max[k]) begin
                failures++;
                $display("[TB] FAIL tol_minmax%0d: min=%0d max=%0d, want %0d/%0d",
                         k, cnt_min, cnt_max, tol_min[k], tol_max[k]);
            end
        end
        assertions++;
        if (fault !== 1'b1 || fault_cnt !== 16'd1) begin
            failures++;
            $display("[TB] FAIL tol_fault: fault=%0b fault_cnt=%0d, want 1/1", fault, fault_cnt);
        end
        @(negedge clk_25M_dect);
        assertions++;
        if (alarm_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL alarm_width1: alarm_pulse=%0b one cycle later, want 0", alarm_pulse);
        end
    endtask

    task automatic test_recovery();
        for (int i = 1; i <= 16; i++) begin
            wait_sample(10'd156, 1'b1);
            assertions++;
            if (state !== ((i == 16) ? 2'd2 : 2'd1)) begin
                failures++;
                $display("[TB] FAIL recover_step%0d: state=%0d want %0d", i, state, (i == 16) ? 2 : 1);
            end
        end
        assertions++;
        if (fault !== 1'b1 || fault_cnt !== 16'd1 || cnt_min !== 10'd150 || cnt_max !== 10'd162) begin
            failures++;
            $display("[TB] FAIL recover_stats: fault=%0b fc=%0d min=%0d max=%0d, want 1/1/150/162",
                     fault, fault_cnt, cnt_min, cnt_max);
        end
    endtask

    logic [9:0] flt_cnt [6] = '{10'd170, 10'd170, 10'd156, 10'd170, 10'd170, 10'd170};

    task automatic test_fault();
        for (int k = 0; k < 6; k++) begin
            wait_sample(flt_cnt[k], 1'b1);
            assertions++;
            if (state !== ((k == 5) ? 2'd3 : 2'd2) || alarm_pulse !== (k == 5)) begin
                failures++;
                $display("[TB] FAIL fault_step%0d: state=%0d alarm=%0b, want %0d/%0b",
                         k, state, alarm_pulse, (k == 5) ? 3 : 2, (k == 5));
            end
        end
        assertions++;
        if (fault_cnt !== 16'd2 || cnt_max !== 10'd170 || cnt_min !== 10'd150) begin
            failures++;
            $display("[TB] FAIL fault_stats: fc=%0d max=%0d min=%0d, want 2/170/150", fault_cnt, cnt_max, cnt_min);
        end
        @(negedge clk_25M_dect);
        assertions++;
        if (alarm_pulse !== 1'b0 || state !== 2'd3) begin
            failures++;
            $display("[TB] FAIL alarm_width2: alarm=%0b state=%0d, want 0/3", alarm_pulse, state);
        end
    endtask

    task automatic test_clr_stat();
        clr_stat = 1'b1;
        @(negedge clk_25M_dect);
        clr_stat = 1'b0;
        assertions++;
        if ({fault, fault_cnt, cnt_min, cnt_max, cnt_last, state} !== {1'b0, 16'd0, 10'h3FF, 10'd0, 10'd0, 2'd3}) begin
            failures++;
            $display("[TB] FAIL clr_stat: f=%0b fc=%0d min=%h max=%0d last=%0d st=%0d, want 0/0/3ff/0/0/3",
                     fault, fault_cnt, cnt_min, cnt_max, cnt_last, state);
        end
    endtask

    task automatic test_unstable();
        int pulses = 0;
        int bad_state = 0;
        for (int i = 0; i < 130; i++) begin
            clk_cnt_in = (i % 2 == 0) ? 10'd156 : 10'd157;
            @(negedge clk_25M_dect);
            if (sample_valid !== 1'b0) pulses++;
            if (state !== 2'd3) bad_state++;
        end
        assertions++;
        if (pulses != 0 || bad_state != 0) begin
            failures++;
            $display("[TB] FAIL unstable_skip: %0d sample pulses, %0d cycles off FAULT, want 0/0", pulses, bad_state);
        end
        wait_sample(10'd156, 1'b1);
        assertions++;
        if ({state, cnt_last, cnt_min, cnt_max} !== {2'd1, 10'd156, 10'd156, 10'd156}) begin
            failures++;
            $display("[TB] FAIL unstable_resume: st=%0d last=%0d min=%0d max=%0d, want 1/156/156/156",
                     state, cnt_last, cnt_min, cnt_max);
        end
    endtask

    task automatic test_coincident_clr();
        for (int i = 0; i < 15; i++) wait_sample(10'd156, 1'b1);
        assertions++;
        if (state !== 2'd2) begin
            failures++;
            $display("[TB] FAIL relock1: state=%0d want 2", state);
        end
        wait_sample(10'd170, 1'b1);
        wait_sample(10'd170, 1'b1);
        // 50 cycles after an observed pulse the window timer sits on the sample phase again.
        repeat (50) @(negedge clk_25M_dect);
        clr_stat = 1'b1;
        @(negedge clk_25M_dect);
        clr_stat = 1'b0;
        assertions++;
        if ({sample_valid, state, alarm_pulse, fault, fault_cnt} !== {1'b1, 2'd3, 1'b1, 1'b1, 16'd1}) begin
            failures++;
            $display("[TB] FAIL coincide_ctrl: sv=%0b st=%0d al=%0b f=%0b fc=%0d, want 1/3/1/1/1",
                     sample_valid, state, alarm_pulse, fault, fault_cnt);
        end
        assertions++;
        if ({cnt_last, cnt_min, cnt_max} !== {10'd170, 10'd170, 10'd170}) begin
            failures++;
            $display("[TB] FAIL coincide_seed: last=%0d min=%0d max=%0d, want 170/170/170", cnt_last, cnt_min, cnt_max);
        end
    endtask

    task automatic test_enable_drop();
        int pulses = 0;
        for (int i = 0; i < 16; i++) wait_sample(10'd156, 1'b1);
        assertions++;
        if (state !== 2'd2) begin
            failures++;
            $display("[TB] FAIL relock2: state=%0d want 2", state);
        end
        enable = 1'b0;
        @(negedge clk_25M_dect);
        assertions++;
        if ({state, locked, fault, fault_cnt, cnt_min, cnt_max} !== {2'd0, 1'b0, 1'b1, 16'd1, 10'd156, 10'd170}) begin
            failures++;
            $display("[TB] FAIL enable_drop: st=%0d lk=%0b f=%0b fc=%0d min=%0d max=%0d, want 0/0/1/1/156/170",
                     state, locked, fault, fault_cnt, cnt_min, cnt_max);
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_25M_dect);
            if (sample_valid !== 1'b0 || state !== 2'd0) pulses++;
        end
        assertions++;
        if (pulses != 0) begin
            failures++;
            $display("[TB] FAIL disabled_quiet: %0d active cycles while disabled, want 0", pulses);
        end
        enable = 1'b1;
        @(negedge clk_25M_dect);
        assertions++;
        if (state !== 2'd1) begin
            failures++;
            $display("[TB] FAIL reenable: state=%0d want 1", state);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) wait_sample(10'd156, 1'b1);
        for (int i = 0; i < 3; i++) wait_sample(10'd170, 1'b1);
        assertions++;
        if (state !== 2'd3 || fault_cnt !== 16'd2) begin
            failures++;
            $display("[TB] FAIL prefault: state=%0d fc=%0d, want 3/2", state, fault_cnt);
        end
        rst = 1'b1;
        @(negedge clk_25M_dect);
        assertions++;
        if ({state, locked, fault, alarm_pulse, sample_valid, cnt_last, cnt_min, cnt_max, fault_cnt} !==
            {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'h3FF, 10'd0, 16'd0}) begin
            failures++;
            $display("[TB] FAIL reset_mid: st=%0d lk=%0b f=%0b al=%0b sv=%0b last=%0d min=%h max=%0d fc=%0d",
                     state, locked, fault, alarm_pulse, sample_valid, cnt_last, cnt_min, cnt_max, fault_cnt);
        end
        rst    = 1'b0;
        enable = 1'b0;
        @(negedge clk_25M_dect);
    endtask

    initial begin
        test_reset();
        test_lock();
        test_tolerance();
        test_recovery();
        test_fault();
        test_clr_stat();
        test_unstable();
        test_coincident_clr();
        test_enable_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
